// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the data-memory responder: RV32I load/store
//   funct3 width codes, the responder state encoding and the word size.
//   No ports; imported by dmem_responder and dmem_lane_align.
package dmem_pkg;

  // RV32I funct3 width codes shared by loads and stores.  Bit 2 set on a
  // load means zero-extend; bits 1:0 give log2 of the access size.
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
//   Purely combinational byte-lane steering for one load/store.
//   Ports:
//     funct3      in   3  RV32I load/store width code
//     addr_lo     in   2  byte lane of the access (addr[1:0])
//     we          in   1  1 = store, 0 = load
//     wdata       in  32  right-aligned store data
//     raw_word    in  32  word currently held at the addressed index
//     byte_en     out  4  lanes to write (all zero when the access is bad)
//     wdata_lane  out 32  store data replicated onto every candidate lane
//     load_data   out 32  extracted and sign/zero-extended load result
//     bad_access  out  1  misaligned access or illegal funct3
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data,
  output logic        bad_access
);

  logic        illegal;
  logic        misalign;
  logic [31:0] shifted;

  // Legality and alignment.  Stores only know B/H/W; loads also have the
  // unsigned B/H variants.  Alignment depends only on the size bits.
  always_comb begin
    illegal = 1'b0;
    if (we) begin
      illegal = (funct3 > F3_W);
    end else begin
      illegal = !((funct3 == F3_B)  || (funct3 == F3_H) || (funct3 == F3_W) ||
                  (funct3 == F3_BU) || (funct3 == F3_HU));
    end
    misalign = 1'b0;
    case (funct3[1:0])
      2'd1:    misalign = addr_lo[0];
      2'd2:    misalign = (addr_lo != 2'd0);
      default: misalign = 1'b0;
    endcase
    bad_access = illegal | misalign;
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted   = raw_word >> {addr_lo, 3'b000};
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = raw_word;
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

  // Store path: replicate the data across the word so any lane selected by
  // byte_en already sees the right bits; no per-lane shifter is needed.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = wdata;
    case (funct3[1:0])
      2'd0: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'd1: begin
        byte_en    = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
      end
      2'd2: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
      end
      default: begin
        byte_en    = 4'b0000;
        wdata_lane = wdata;
      end
    endcase
    if (bad_access) begin
      byte_en = 4'b0000;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Slave end of the CPU load/store interface.  Accepts one request at a
//   time, waits LATENCY cycles, performs a byte-lane-aware access on an
//   internal DEPTH x 32-bit word array and returns data/error on a
//   valid/ready response channel.
//   Ports:
//     clk_i         in   1  clock, rising edge
//     rst_i         in   1  asynchronous active-low reset
//     req_valid_i   in   1  request valid
//     req_ready_o   out  1  responder can accept a request (IDLE only)
//     req_we_i      in   1  1 = store, 0 = load
//     req_funct3_i  in   3  RV32I width code
//     req_addr_i    in  32  byte address
//     req_wdata_i   in  32  right-aligned store data
//     rsp_valid_o   out  1  response valid
//     rsp_ready_i   in   1  requester accepts the response
//     rsp_rdata_o   out 32  extended load result, 0 for stores and errors
//     rsp_err_o     out  1  misaligned, illegal funct3 or out of range
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

  logic [31:0] mem [DEPTH];

  dmem_state_e state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [29:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             out_of_range;
  logic [31:0]      raw_word;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_lane;
  logic [31:0]      load_data;
  logic             bad_access;
  logic             access_err;
  logic             do_write;

  // Ready is gated by rst_i so it drops the instant reset is asserted,
  // not on the next edge.
  assign req_ready_o = (state == IDLE) && rst_i;
  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // Address decode works from the captured request only, so req_* may
  // change freely while the responder is busy.  When out of range the
  // truncated index reads some other word, but that value is discarded.
  always_comb begin
    word_idx     = addr_q[31:2];
    mem_idx      = word_idx[IDX_W-1:0];
    out_of_range = (word_idx >= DEPTH_W);
    raw_word     = mem[mem_idx];
    access_err   = bad_access | out_of_range;
    do_write     = (state == ACCESS) && we_q && !access_err;
  end

  dmem_lane_align u_lane_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .we         (we_q),
    .wdata      (wdata_q),
    .raw_word   (raw_word),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .load_data  (load_data),
    .bad_access (bad_access)
  );

  // The array has no reset: contents survive rst_i.  A write only fires on
  // the edge leaving ACCESS, and reset forces IDLE asynchronously, so a
  // store interrupted by reset never writes any lane.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (byte_en[k]) begin
          mem[mem_idx][8*k +: 8] <= wdata_lane[8*k +: 8];
        end
      end
    end
  end

  // Request/response sequencing.  WAIT leaves at count 1, which together
  // with the single ACCESS cycle puts rsp_valid_o LATENCY+1 edges after
  // the accept edge.  A request presented during RESP is not taken until
  // the following IDLE cycle, because ready is only high in IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            if (LATENCY == 0) begin
              state <= ACCESS;
            end else begin
              state    <= WAIT;
              wait_cnt <= LAT_CNT;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          err_q   <= access_err;
          rdata_q <= (we_q || access_err) ? 32'd0 : load_data;
          state   <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state   <= IDLE;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Bench for dmem_responder: one instance at LATENCY=2 and one at
//   LATENCY=0, checked against a byte-array reference model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [2:0]  req_f30;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we0),
    .req_funct3_i(req_f30), .req_addr_i(req_addr0), .req_wdata_i(req_wdata0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0),
    .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference memory for the LATENCY=2 instance, one entry per byte.
  logic [7:0] mem_m [0:4*DEPTH-1];

  // Reference behaviour from the access rules: size from funct3, natural
  // alignment, range check, little-endian byte assembly and extension.
  function automatic void model_op(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   output logic [31:0] rd, output logic er);
    int          size;
    logic        legal;
    logic [31:0] val;
    rd    = 32'd0;
    er    = 1'b0;
    legal = we ? (f3 <= 3'd2) : ((f3 != 3'd3) && (f3 < 3'd6));
    size  = 1 << f3[1:0];
    if (!legal || ((a % size) != 0) || ((a / 4) >= DEPTH)) begin
      er = 1'b1;
    end else if (we) begin
      for (int i = 0; i < size; i++) mem_m[a + i] = wd[8*i +: 8];
    end else begin
      val = 32'd0;
      for (int i = 0; i < size; i++) val = val | (32'(mem_m[a + i]) << (8 * i));
      if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
      if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
      rd = val;
    end
  endfunction

  task automatic set_req(input bit sel, input logic v, input logic we,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    if (sel) begin
      req_valid0 = v; req_we0 = we; req_f30 = f3; req_addr0 = a; req_wdata0 = wd;
    end else begin
      req_valid = v; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
    end
  endtask

  task automatic set_rsp_ready(input bit sel, input logic v);
    if (sel) rsp_ready0 = v; else rsp_ready = v;
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? req_ready0 : req_ready;
  endfunction
  function automatic logic get_valid(input bit sel);
    return sel ? rsp_valid0 : rsp_valid;
  endfunction
  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? rsp_rdata0 : rsp_rdata;
  endfunction
  function automatic logic get_err(input bit sel);
    return sel ? rsp_err0 : rsp_err;
  endfunction

  // One full transaction, entered just after a rising edge.  Request fields
  // are scrambled right after acceptance; the response is held for `hold`
  // cycles before rsp_ready is raised.  lat counts edges from accept to
  // rsp_valid; post_* are the outputs just after the handshake edge.
  task automatic applyStimulus(input bit sel, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd, input int hold,
                               output logic [31:0] rd, output logic er, output int lat,
                               output logic post_valid, output logic [31:0] post_rdata);
    int n;
    rd = 32'd0; er = 1'b0; lat = -1; post_valid = 1'b0; post_rdata = 32'd0;
    set_req(sel, 1'b1, we, f3, addr, wd);
    n = 0;
    while (!get_ready(sel) && n < 40) begin @(posedge clk); #1; n++; end
    if (!get_ready(sel)) begin
      compared++; mismatched++;
      $display("[TB] FAIL accept_timeout: req_ready stayed %b, required 1", get_ready(sel));
      set_req(sel, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      return;
    end
    @(posedge clk); #1;
    set_req(sel, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!get_valid(sel) && lat < 40);
    if (!get_valid(sel)) begin
      compared++; mismatched++;
      $display("[TB] FAIL rsp_timeout: rsp_valid stayed %b, required 1", get_valid(sel));
      return;
    end
    rd = get_rdata(sel);
    er = get_err(sel);
    repeat (hold) begin @(posedge clk); #1; end
    set_rsp_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_rsp_ready(sel, 1'b0);
    post_valid = get_valid(sel);
    post_rdata = get_rdata(sel);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    rsp_ready = 1'b0; rsp_ready0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h, required all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL idle_ready: ready=%b ready0=%b, required 1", req_ready, req_ready0);
    end
  endtask

  // Give every word a known random value so later loads are never X.
  task automatic test_fill();
    logic [31:0] rd, exp_rd, pr, wd;
    logic er, exp_er, pv;
    int lat;
    for (int i = 0; i < DEPTH; i++) begin
      wd = $urandom;
      applyStimulus(0, 1'b1, F3_W, 32'(i * 4), wd, 0, rd, er, lat, pv, pr);
      model_op(1'b1, F3_W, 32'(i * 4), wd, exp_rd, exp_er);
      compared++;
      if (er !== 1'b0 || rd !== 32'd0 || lat != 3) begin
        mismatched++;
        $display("[TB] FAIL fill_store[%0d]: err=%b rdata=%h lat=%0d, required 0/0/3", i, er, rd, lat);
      end
    end
  endtask

  task automatic test_directed();
    logic        d_we   [16] = '{1,0,0,0,0,0,1,0,1,0, 0,1,0,1,0,1};
    logic [2:0]  d_f3   [16] = '{2,2,0,4,1,5,0,2,1,2, 2,2,2,2,2,1};
    logic [31:0] d_addr [16] = '{32'h10,32'h10,32'h13,32'h13,32'h12,32'h10,32'h11,32'h10,32'h12,32'h10,
                                  32'h1FC,32'h1FC,32'h1FC,32'h200,32'h10,32'h13};
    logic [31:0] d_wd   [16] = '{32'hDEADBEEF,0,0,0,0,0,32'hAAAAAA55,0,32'hFFFF1234,0,
                                  0,32'hCAFEF00D,0,32'h11111111,0,32'h7777};
    logic [31:0] d_rd   [16] = '{0,32'hDEADBEEF,32'hFFFFFFDE,32'h000000DE,32'hFFFFDEAD,32'h0000BEEF,
                                  0,32'hDEAD55EF,0,32'h123455EF, 0,0,32'hCAFEF00D,0,32'h123455EF,0};
    logic        d_er   [16] = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,1,0,1};
    logic [31:0] rd, pr, mrd;
    logic er, pv, mer;
    int lat;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, d_we[i], d_f3[i], d_addr[i], d_wd[i], 0, rd, er, lat, pv, pr);
      model_op(d_we[i], d_f3[i], d_addr[i], d_wd[i], mrd, mer);
      if (i == 10) continue;
      compared++;
      if (rd !== d_rd[i] || er !== d_er[i]) begin
        mismatched++;
        $display("[TB] FAIL directed[%0d]: rdata=%h err=%b, required %h/%b", i, rd, er, d_rd[i], d_er[i]);
      end
      compared++;
      if (lat != 3 || pv !== 1'b0 || pr !== 32'd0) begin
        mismatched++;
        $display("[TB] FAIL directed_timing[%0d]: lat=%0d post_valid=%b post_rdata=%h, required 3/0/0",
                 i, lat, pv, pr);
      end
    end
  endtask

  task automatic test_errors();
    logic        e_we   [9] = '{0,1,0,0,0,0,1,1,0};
    logic [2:0]  e_f3   [9] = '{2,1,3,6,7,1,3,4,2};
    logic [31:0] e_addr [9] = '{32'h12,32'h11,32'h10,32'h10,32'h10,32'h13,32'h10,32'h10,32'h10};
    logic [31:0] rd, pr, mrd;
    logic er, pv, mer;
    int lat;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, e_we[i], e_f3[i], e_addr[i], 32'h5A5A5A5A, 0, rd, er, lat, pv, pr);
      model_op(e_we[i], e_f3[i], e_addr[i], 32'h5A5A5A5A, mrd, mer);
      compared++;
      if (i < 8 && (rd !== 32'd0 || er !== 1'b1 || pv !== 1'b0)) begin
        mismatched++;
        $display("[TB] FAIL error_case[%0d]: rdata=%h err=%b post_valid=%b, required 0/1/0", i, rd, er, pv);
      end else if (i == 8 && (rd !== 32'h123455EF || er !== 1'b0)) begin
        mismatched++;
        $display("[TB] FAIL error_no_write: rdata=%h err=%b, required 123455ef/0", rd, er);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp1, exp2;
    logic e1, e2;
    int n;
    model_op(1'b0, F3_W, 32'h10, 32'd0, exp1, e1);
    model_op(1'b0, F3_HU, 32'h12, 32'd0, exp2, e2);
    set_req(0, 1'b1, 1'b0, F3_W, 32'h10, 32'd0);
    @(posedge clk); #1;
    // Keep a different request pending for the whole busy period.
    set_req(0, 1'b1, 1'b0, F3_HU, 32'h12, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    for (int c = 0; c < 5; c++) begin
      compared++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp1 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hold[%0d]: valid=%b rdata=%h err=%b ready=%b, required 1/%h/0/0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, exp1);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    compared++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || req_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL handshake_release: valid=%b rdata=%h ready=%b, required 0/0/1",
               rsp_valid, rsp_rdata, req_ready);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL second_accept: ready=%b, required 0", req_ready);
    end
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    compared++;
    if (n != 3 || rsp_rdata !== exp2 || rsp_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL second_rsp: lat=%0d rdata=%h err=%b, required 3/%h/0", n, rsp_rdata, rsp_err, exp2);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_rd, rd, pr;
    logic exp_er, er, pv;
    int lat;
    model_op(1'b0, F3_W, 32'h20, 32'd0, exp_rd, exp_er);
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pre_store_ready: ready=%b, required 1", req_ready);
    end
    set_req(0, 1'b1, 1'b1, F3_W, 32'h20, 32'h1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: ready=%b valid=%b err=%b rdata=%h, required all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, F3_W, 32'h20, 32'd0, 0, rd, er, lat, pv, pr);
    compared++;
    if (rd !== exp_rd || er !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dropped_store: rdata=%h err=%b, required %h/0", rd, er, exp_rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rd, pr, exp_rd;
    logic [2:0] f3;
    logic we, er, pv, exp_er;
    int lat;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      if ($urandom_range(0, 9) < 8) addr = 32'($urandom_range(0, 4 * DEPTH - 1));
      else addr = $urandom;
      wd = $urandom;
      applyStimulus(0, we, f3, addr, wd, $urandom_range(0, 3), rd, er, lat, pv, pr);
      model_op(we, f3, addr, wd, exp_rd, exp_er);
      compared++;
      if (rd !== exp_rd || er !== exp_er) begin
        mismatched++;
        $display("[TB] FAIL random[%0d] we=%b f3=%0d addr=%h: rdata=%h err=%b, required %h/%b",
                 i, we, f3, addr, rd, er, exp_rd, exp_er);
      end
      compared++;
      if (lat != 3 || pv !== 1'b0 || pr !== 32'd0) begin
        mismatched++;
        $display("[TB] FAIL random_timing[%0d]: lat=%0d post_valid=%b post_rdata=%h, required 3/0/0",
                 i, lat, pv, pr);
      end
    end
  endtask

  task automatic test_latency0();
    logic [31:0] rd, pr;
    logic er, pv;
    int lat;
    applyStimulus(1, 1'b1, F3_W, 32'h40, 32'h8badf00d, 0, rd, er, lat, pv, pr);
    compared++;
    if (lat != 1 || rd !== 32'd0 || er !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL lat0_store: lat=%0d rdata=%h err=%b, required 1/0/0", lat, rd, er);
    end
    applyStimulus(1, 1'b0, F3_B, 32'h43, 32'd0, 1, rd, er, lat, pv, pr);
    compared++;
    if (lat != 1 || rd !== 32'hFFFFFF8B || er !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL lat0_load: lat=%0d rdata=%h err=%b, required 1/ffffff8b/0", lat, rd, er);
    end
  endtask

  // Requests held valid with rsp_ready tied high: accept edges must be
  // LATENCY+3 cycles apart.
  task automatic test_back_to_back(input bit sel, input int period);
    int t [3];
    int acc, cyc;
    logic rdy;
    acc = 0; cyc = 0;
    set_rsp_ready(sel, 1'b1);
    set_req(sel, 1'b1, 1'b0, F3_W, 32'h40, 32'd0);
    while (acc < 3 && cyc < 60) begin
      rdy = get_ready(sel);
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin t[acc] = cyc; acc++; end
    end
    set_req(sel, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    set_rsp_ready(sel, 1'b0);
    compared++;
    if (acc < 3) begin
      mismatched++;
      $display("[TB] FAIL b2b_timeout[%0d]: accepts=%0d, required 3", sel, acc);
    end else if ((t[1] - t[0]) != period || (t[2] - t[1]) != period) begin
      mismatched++;
      $display("[TB] FAIL b2b_period[%0d]: gaps=%0d,%0d, required %0d", sel, t[1] - t[0], t[2] - t[1], period);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_latency0();
    test_back_to_back(0, 5);
    test_back_to_back(1, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
